can_uart_tx: RTL and testbench

Downstream stage of `can_rx` in the UART–CAN bridge. It captures each byte `can_rx` presents on `Can_rx_data_Bus`/`Can_data_ready` and buffers it in a small FIFO. It then serialises the bytes onto the UART line as 8N1 frames, LSB first, at a fixed bit period. It decouples CAN frame bursts (up to 8 data bytes back-to-back) from the slower UART drain.

---
 rtl/can_uart_tx.sv | 128 ++++++++++++
 tb/tb_can_uart_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/can_uart_tx.sv
// can_uart_tx: captures bytes from can_rx into a small FIFO and drains them
// onto the UART line as 8N1 frames, LSB first, at a fixed bit period.
module can_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    Can_rx_data_Bus,
    input  logic                          Can_data_ready,
    output logic                          Uart_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_C   = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          r_state, w_state_n;
    logic [TW-1:0]   r_timer, w_timer_n;
    logic [2:0]      r_bit, w_bit_n;
    logic [7:0]      r_shift, w_shift_n;
    logic            r_tx, w_tx_n;
    logic            r_dr_q;
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_ovf;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic            w_push_req, w_push, w_pop, w_tick;

    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign w_push_req = Can_data_ready & ~r_dr_q;
    assign w_push     = w_push_req & ((r_count < DEPTH_C) | w_pop);
    assign w_tick     = (r_timer == LAST_TICK);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_dr_q   <= 1'b1;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_dr_q <= Can_data_ready;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_req && !w_push) r_ovf <= 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && w_push) r_mem[r_wr_ptr] <= Can_rx_data_Bus;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_timer <= w_timer_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_tx    <= w_tx_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_timer_n = r_timer + 1'b1;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_pop     = 1'b0;
        case (r_state)
            IDLE: begin
                w_timer_n = '0;
                if (r_count != '0) begin
                    w_pop     = 1'b1;
                    w_shift_n = r_mem[r_rd_ptr];
                    w_state_n = START;
                end
            end
            START: if (w_tick) begin
                w_timer_n = '0;
                w_bit_n   = '0;
                w_state_n = DATA;
            end
            DATA: if (w_tick) begin
                w_timer_n = '0;
                w_shift_n = {1'b0, r_shift[7:1]};
                if (r_bit == 3'd7) w_state_n = STOP;
                else               w_bit_n   = r_bit + 1'b1;
            end
            STOP: if (w_tick) begin
                w_timer_n = '0;
                w_state_n = IDLE;
            end
            default: w_state_n = IDLE;
        endcase
    end

    // Line level is decided from the next state so the registered output
    // changes on the same edge as the state.
    always_comb begin
        w_tx_n = 1'b1;
        case (w_state_n)
            START:   w_tx_n = 1'b0;
            DATA:    w_tx_n = w_shift_n[0];
            default: w_tx_n = 1'b1;
        endcase
    end

    assign Uart_tx    = r_tx;
    assign tx_busy    = (r_state != IDLE);
    assign fifo_count = r_count;
    assign overflow   = r_ovf;
endmodule

// File: tb/tb_can_uart_tx.sv
// Bench for can_uart_tx: instance A (4 clk/bit, depth 16) and instance B
// (16 clk/bit, depth 4) share the byte input stream and reset.
module tb_can_uart_tx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       rdy;
    logic [7:0] dat;

    logic       a_tx, a_busy, a_ovf;
    logic [4:0] a_cnt;
    logic       b_tx, b_busy, b_ovf;
    logic [2:0] b_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic a_tx_s [1400];
    logic a_busy_s [1400];
    int   a_cnt_s [1400];
    logic b_tx_s [1400];
    logic b_busy_s [1400];
    int   b_cnt_s [1400];
    logic b_ovf_s [1400];

    always #5 clk = ~clk;

    can_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16)) u_a (
        .clock(clk), .reset(rst_n), .Can_rx_data_Bus(dat), .Can_data_ready(rdy),
        .Uart_tx(a_tx), .tx_busy(a_busy), .fifo_count(a_cnt), .overflow(a_ovf));

    can_uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) u_b (
        .clock(clk), .reset(rst_n), .Can_rx_data_Bus(dat), .Can_data_ready(rdy),
        .Uart_tx(b_tx), .tx_busy(b_busy), .fifo_count(b_cnt), .overflow(b_ovf));

    typedef struct {
        logic [7:0] data;
        logic [9:0] bits;   // line levels in transmit order, first bit at MSB
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Sample m is taken just after edge E0+m; bytes are pushed at edges m=0,2,4..
    // (or held from m=0 for 'hold' cycles when npush==1).
    task automatic run(input logic [7:0] base, input int npush, input int hold, input int ncyc);
        for (int m = 0; m < ncyc; m++) begin
            if (npush == 1) begin
                rdy = (m < hold);
                dat = base;
            end else begin
                rdy = (m % 2 == 0) && (m / 2 < npush);
                dat = base + 8'(m / 2);
            end
            @(posedge clk);
            @(negedge clk);
            a_tx_s[m] = a_tx;  a_busy_s[m] = a_busy;  a_cnt_s[m] = int'(a_cnt);
            b_tx_s[m] = b_tx;  b_busy_s[m] = b_busy;  b_cnt_s[m] = int'(b_cnt);
            b_ovf_s[m] = b_ovf;
        end
        rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic samp(input bit use_b, input int idx);
        return use_b ? b_tx_s[idx] : a_tx_s[idx];
    endfunction

    task automatic decode(input bit use_b, input int base, input int cpb,
                          input logic [7:0] exp, input string nm);
        logic [7:0] d;
        logic s0, s9;
        s0 = samp(use_b, base + cpb / 2);
        for (int k = 0; k < 8; k++) d[k] = samp(use_b, base + cpb * (k + 1) + cpb / 2);
        s9 = samp(use_b, base + cpb * 9 + cpb / 2);
        chk({nm, "_framing"}, {s0, s9}, 2'b01);
        chk({nm, "_byte"}, d, exp);
    endtask

    initial begin
        int cnt;
        logic [9:0] got;

        vecs[0] = '{8'h41, 10'b0100000101};
        vecs[1] = '{8'h00, 10'b0000000001};
        vecs[2] = '{8'hFF, 10'b0111111111};
        vecs[3] = '{8'hA5, 10'b0101001011};
        vecs[4] = '{8'h0F, 10'b0111100001};
        vecs[5] = '{8'h80, 10'b0000000011};

        // Reset with the ready level already high: it must not be captured.
        rst_n = 1'b0;
        rdy   = 1'b1;
        dat   = 8'h77;
        repeat (3) @(negedge clk);
        chk("rst_a_outputs", {a_tx, a_busy, a_cnt, a_ovf}, {1'b1, 1'b0, 5'd0, 1'b0});
        chk("rst_b_outputs", {b_tx, b_busy, b_cnt, b_ovf}, {1'b1, 1'b0, 3'd0, 1'b0});
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("held_at_release_a", {a_cnt, a_busy, a_tx}, {5'd0, 1'b0, 1'b1});
        chk("held_at_release_b", {b_cnt, b_busy}, {3'd0, 1'b0});
        rdy = 1'b0;
        @(negedge clk);

        // Single-byte frames on A from the vector table
        foreach (vecs[v]) begin
            run(vecs[v].data, 1, 1, 50);
            chk($sformatf("v%0d_capture", v), {a_cnt_s[0][4:0], a_tx_s[0], a_busy_s[0]}, {5'd1, 1'b1, 1'b0});
            chk($sformatf("v%0d_latency", v), {a_cnt_s[1][4:0], a_tx_s[1], a_busy_s[1]}, {5'd0, 1'b0, 1'b1});
            got = '0;
            for (int k = 0; k < 10; k++) got = {got[8:0], a_tx_s[1 + 4 * k + 2]};
            chk($sformatf("v%0d_bits", v), got, vecs[v].bits);
            cnt = 0;
            for (int m = 0; m < 50; m++) if (a_busy_s[m]) cnt++;
            chk($sformatf("v%0d_busy_len", v), cnt, 40);
            chk($sformatf("v%0d_end_idle", v), {a_busy_s[40], a_busy_s[41], a_tx_s[41]}, 3'b101);
        end

        // Burst of 8 bytes every 2 cycles on A
        run(8'h41, 8, 1, 340);
        cnt = 0;
        for (int m = 0; m < 340; m++) if (a_cnt_s[m] > cnt) cnt = a_cnt_s[m];
        chk("burst_peak_count", cnt, 7);
        for (int j = 0; j < 8; j++) begin
            decode(1'b0, 1 + 41 * j, 4, 8'h41 + 8'(j), $sformatf("burst_f%0d", j));
            if (j > 0) chk($sformatf("burst_gap%0d", j), {a_busy_s[41 * j], a_tx_s[41 * j], a_busy_s[41 * j + 1]}, 3'b011);
        end
        chk("burst_drained", {a_busy_s[339], a_cnt_s[339][4:0]}, {1'b0, 5'd0});

        // Held level: one push, one frame
        run(8'h55, 1, 50, 200);
        decode(1'b0, 1, 4, 8'h55, "held_f0");
        cnt = 0;
        for (int m = 1; m < 200; m++) if (a_busy_s[m] && !a_busy_s[m - 1]) cnt++;
        chk("held_frame_count", cnt, 1);
        cnt = 0;
        for (int m = 0; m < 200; m++) if (a_cnt_s[m] > cnt) cnt = a_cnt_s[m];
        chk("held_peak_count", cnt, 1);

        // Reset during DATA bit 3 of A, with a second byte still queued
        run(8'hA5, 2, 1, 18);
        chk("pre_reset_state", {a_busy_s[17], a_cnt_s[17][4:0]}, {1'b1, 5'd1});
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_a", {a_tx, a_busy, a_cnt}, {1'b1, 1'b0, 5'd0});
        rst_n = 1'b1;
        run(8'h00, 0, 1, 120);
        cnt = 0;
        for (int m = 0; m < 120; m++) if (a_busy_s[m] || !a_tx_s[m] || a_cnt_s[m] != 0) cnt++;
        chk("midreset_quiet", cnt, 0);
        run(8'h3C, 1, 1, 50);
        decode(1'b0, 1, 4, 8'h3C, "after_reset_f0");

        // Overflow on B: 0x15 is dropped
        do_reset();
        run(8'h10, 6, 1, 1000);
        chk("ovf_full", b_cnt_s[8], 4);
        chk("ovf_before", b_ovf_s[9], 1'b0);
        chk("ovf_set", {b_ovf_s[10], b_cnt_s[10][2:0]}, {1'b1, 3'd4});
        for (int j = 0; j < 5; j++) decode(1'b1, 1 + 161 * j, 16, 8'h10 + 8'(j), $sformatf("ovf_f%0d", j));
        cnt = 0;
        for (int m = 806; m < 1000; m++) if (b_busy_s[m] || b_cnt_s[m] != 0) cnt++;
        chk("ovf_no_sixth", cnt, 0);
        chk("ovf_sticky", b_ovf_s[999], 1'b1);

        // Full FIFO on B with a push on the popping edge
        do_reset();
        run(8'h20, 5, 1, 162);
        chk("fullpop_stop", {b_busy_s[160], b_cnt_s[160][2:0]}, {1'b1, 3'd4});
        chk("fullpop_idle", {b_busy_s[161], b_cnt_s[161][2:0]}, {1'b0, 3'd4});
        rdy = 1'b1;
        dat = 8'h25;
        @(posedge clk);
        @(negedge clk);
        chk("fullpop_edge", {b_cnt, b_ovf, b_busy, b_tx}, {3'd4, 1'b0, 1'b1, 1'b0});
        run(8'h00, 0, 1, 1200);
        for (int k = 2; k < 6; k++)
            decode(1'b1, 161 * k - 162, 16, 8'h20 + 8'(k), $sformatf("fullpop_f%0d", k));
        chk("fullpop_no_ovf", {b_ovf_s[1199], b_busy_s[1199], b_cnt_s[1199][2:0]}, {1'b0, 1'b0, 3'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
